// File: rtl/div_share_arbiter_pkg.sv
// rtl/div_share_arbiter_pkg.sv - shared types and constants for the divider-sharing arbiter
package div_share_arbiter_pkg;

  localparam int TAG_W = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_t;

  function automatic int tag_width(input int p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - requester-side bundle: operand requests, grants and result return
interface div_share_arbiter_if #(
  parameter int N = 16,
  parameter int P = 4
);
  logic [P-1:0]   REQ_R;
  logic [P*N-1:0] REQ_D;
  logic [P-1:0]   GNT;
  logic [P-1:0]   RES_V;
  logic [N-1:0]   RES_D;

  modport master (output REQ_R, REQ_D, input GNT, RES_V, RES_D);
  modport slave  (input REQ_R, REQ_D, output GNT, RES_V, RES_D);
endinterface

// File: rtl/div_share_arbiter_rr_pick.sv
// rtl/div_share_arbiter_rr_pick.sv - round-robin one-hot picker starting the scan at ptr
module div_share_arbiter_rr_pick #(
  parameter int P  = 4,
  parameter int TW = 2
) (
  input  logic [P-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic [P-1:0]  gnt,
  output logic [TW-1:0] idx,
  output logic          any
);

  logic [TW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < P; k++) begin
      j = TW'((int'(ptr) + k) % P);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - shares one fixed-latency EN-gated operator among P requesters
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter int N   = 16,
  parameter int P   = 4,
  parameter int LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                FLUSH,
  div_share_arbiter_if.slave  bus,
  output logic                FLUSH_DONE,
  output logic                ERR,
  output logic                OP_EN,
  output logic                OP_R_IN,
  output logic [N-1:0]        OP_D_IN,
  input  logic                OP_R_OUT,
  input  logic [N-1:0]        OP_D_OUT
);

  localparam int TW = tag_width(P);

  logic [1:0]    state;
  logic [TW-1:0] ptr;
  logic          adv;
  tag_t          pipe [LAT+1];
  tag_t          last;
  logic [P-1:0]  pick_gnt;
  logic [TW-1:0] pick_idx;
  logic          pick_any;
  logic          grant_ok;
  logic          granted;
  logic          pipe_empty;
  logic [N-1:0]  sel_d;
  logic [P-1:0]  res_v;

  div_share_arbiter_rr_pick #(.P(P), .TW(TW)) u_pick (
    .req (bus.REQ_R),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // RST gates the grant so that GNT reads zero while reset is held
  assign grant_ok   = RST && EN && !FLUSH && (state == ST_RUN);
  assign granted    = grant_ok && pick_any;
  assign bus.GNT    = grant_ok ? pick_gnt : '0;
  assign OP_EN      = EN;
  assign last       = pipe[LAT];
  assign bus.RES_D  = OP_D_OUT;
  assign bus.RES_V  = res_v;
  assign FLUSH_DONE = (state == ST_DONE) && FLUSH;

  always_comb begin
    sel_d      = '0;
    res_v      = '0;
    pipe_empty = 1'b1;
    for (int i = 0; i < P; i++) begin
      if (pick_idx == TW'(i)) sel_d = bus.REQ_D[i*N +: N];
      res_v[i] = adv && OP_R_OUT && last.valid && (last.tag == TAG_W'(i));
    end
    for (int s = 0; s <= LAT; s++) begin
      if (pipe[s].valid) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OP_R_IN <= 1'b0;
      OP_D_IN <= '0;
      ptr     <= '0;
      adv     <= 1'b0;
      ERR     <= 1'b0;
      state   <= ST_RUN;
      for (int s = 0; s <= LAT; s++) pipe[s] <= '0;
    end else begin
      adv <= EN;
      // operator holds its output while EN=0, so only freshly advanced results are judged
      if (adv && (OP_R_OUT != last.valid)) ERR <= 1'b1;
      if (EN) begin
        OP_R_IN <= granted;
        if (granted) begin
          OP_D_IN <= sel_d;
          ptr     <= (pick_idx == TW'(P-1)) ? '0 : pick_idx + 1'b1;
        end
        pipe[0] <= '{valid: granted, tag: TAG_W'(pick_idx)};
        for (int s = 1; s <= LAT; s++) pipe[s] <= pipe[s-1];
      end
      case (state)
        ST_RUN:   if (FLUSH) state <= ST_DRAIN;
        ST_DRAIN: if (EN && pipe_empty) state <= ST_DONE;
        ST_DONE:  if (!FLUSH) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
Round-robin arbiter that shares one divide-by-constant dataflow operator (R/D valid-data style, EN-gated, fixed latency) among P requesters. It registers the granted operand into the operator and carries a requester tag alongside the operator pipeline. It routes each returning result back to the requester that issued it. A flush handshake lets the controller quiesce the shared operator before reconfiguration.

Parameters:
N, 16, data width of operands and results
P, 4, number of requesters (2..16)
LAT, 1, operator latency in enabled clock edges from its R_IN/D_IN to its R_OUT/D_OUT
TW, clog2(P), localparam, tag width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
EN  in  1  global enable; drives OP_EN; freezes arbiter, tag pipe and operator when 0
FLUSH  in  1  request to stop issuing and drain in-flight operations
REQ_R  in  P  per-requester operand valid; held until matching GNT bit
REQ_D  in  P*N  operands, requester i at bits [i*N +: N]
GNT  out  P  one-hot combinational grant; operand is accepted this cycle
RES_V  out  P  one-cycle result-valid pulse for the owning requester
RES_D  out  N  result data, broadcast to all requesters, qualified by RES_V
FLUSH_DONE  out  1  high while drained and FLUSH held
ERR  out  1  sticky tag/valid mismatch flag, cleared only by reset
OP_EN  out  1  to operator EN
OP_R_IN  out  1  registered operand valid to operator
OP_D_IN  out  N  registered operand to operator
OP_R_OUT  in  1  operator result valid
OP_D_OUT  in  N  operator result

Behaviour:
- Reset (RST=0, async): GNT=0, RES_V=0, OP_R_IN=0, OP_D_IN=0, FLUSH_DONE=0, ERR=0, PTR=0, all tag stages invalid, state RUN, ADV=0.
- OP_EN = EN, combinational.
- Grant, combinational: only in RUN with EN=1 and FLUSH=0. Select the first i with REQ_R[i]=1, scanning PTR, PTR+1, ... mod P. GNT[i]=1, others 0. No request: GNT=0.
- Issue at each edge with EN=1: OP_R_IN <= |GNT; OP_D_IN <= REQ_D[i] if granted, else unchanged; tag stage 0 <= {|GNT, i}; PTR <= (i+1) mod P only on a grant.
- Tag pipe: LAT+1 stages (stage 0 aligns with OP_R_IN). It shifts only on edges with EN=1. With EN=0 nothing moves and PTR holds.
- ADV <= EN each edge. Results count only when the last edge advanced the pipe, because the operator holds R_OUT while EN=0.
- Return, combinational: RES_V[t] = ADV & OP_R_OUT & last_v & (last_tag==t); RES_D = OP_D_OUT.
- Total latency: operand accepted (GNT) at edge k, RES_V high in the cycle after enabled edge k+LAT+1. With EN stuck at 1 this is LAT+1 cycles after GNT. Throughput is 1 per enabled cycle.
- Error: ERR <= 1 on any edge where ADV=1 and OP_R_OUT != last_v.
- FSM:
  - RUN: FLUSH=1 -> DRAIN. No grants are issued while FLUSH=1.
  - DRAIN: all tag stages invalid -> DONE. EN=0 stalls the drain.
  - DONE: FLUSH_DONE=1. FLUSH=0 -> RUN, and grants resume next cycle. PTR is preserved through the flush.
- Simultaneous requests: strictly one grant per cycle, with no starvation (max wait P-1 grants).
- REQ_R deasserted before grant: request is dropped, no side effect.
- Reset mid-operation: in-flight results are discarded, with no spurious RES_V after RST release.

Decomposition:
- Shared package: TW computation (clog2), state encoding RUN/DRAIN/DONE, tag struct {valid, tag}.
- One sub-module: rr_pick (P-input round-robin one-hot picker, inputs req and ptr, outputs one-hot gnt and index). Tag pipe and FSM live in the top module.

Test Plan:
- P=4, LAT=1, EN=1, operator divides by 2: REQ_R=0001, D=100 -> GNT=0001 at cycle 0, RES_V=0001 and RES_D=50 at cycle 2, ERR=0.
- All four REQ_R held high with distinct operands 10,20,30,40 -> GNT order 0,1,2,3,0. Results return in the same order with matching RES_V bits and values 5,10,15,20.
- EN low for 3 cycles with one operation in flight -> no GNT, no RES_V, OP_EN=0. Result arrives exactly once after EN returns, LAT+1 enabled edges after the grant.
- FLUSH asserted with 2 operations in flight -> no further GNT, both results delivered, then FLUSH_DONE=1. FLUSH=0 -> next grant goes to PTR (round-robin continues).
- Force OP_R_OUT=1 with an empty tag pipe -> ERR=1 on the next edge and stays 1 until RST.
- Assert RST with operations in flight -> all outputs 0 immediately (async). No RES_V after release, and the first grant goes to requester 0.
